// File: rtl/fake_n64_controller_tx.sv
// Fake N64 controller response transmitter.
// Serialises INFO/STATUS/READ/WRITE replies onto the one-wire line.
module fake_n64_controller_tx #(
  parameter int CLKS_PER_US   = 50,
  parameter int TURNAROUND_US = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_handoff,
  input  logic [7:0]  cmd,
  input  logic [15:0] address,
  input  logic [7:0]  crc,
  input  logic [31:0] buttons,
  input  logic [7:0]  pak_status,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        data_tx,
  output logic        cur_operation
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TURN = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_BITL = 3'd3;
  localparam logic [2:0] S_BITH = 3'd4;
  localparam logic [2:0] S_STPL = 3'd5;
  localparam logic [2:0] S_STPH = 3'd6;

  localparam logic [1:0] K_INFO = 2'd0;
  localparam logic [1:0] K_STAT = 2'd1;
  localparam logic [1:0] K_READ = 2'd2;
  localparam logic [1:0] K_WRIT = 2'd3;

  localparam int PW = (CLKS_PER_US > 2) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_US - 1);
  localparam logic [1:0] TURN_M1 = 2'(TURNAROUND_US - 1);

  logic          sync1_q, sync2_q;
  logic          seen_q, armed_q;
  logic          req;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    us_q, us_d;
  logic [2:0]    bit_q, bit_d;
  logic [5:0]    byte_q, byte_d;
  logic [5:0]    len_q, len_d;
  logic [1:0]    kind_q, kind_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    crca_q, crca_d;
  logic [23:0]   btn_q, btn_d;
  logic [10:0]   addr_q, addr_d;
  logic [7:0]    wcrc_q, wcrc_d;
  logic          data_tx_q, cur_op_q;

  logic [7:0]    byte_val;
  logic [1:0]    dur_m1;
  logic          done, last;
  logic          unused_addr;

  assign unused_addr = ^address[4:0];

  function automatic logic [7:0] crc8_step(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h85) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // Synchroniser is unreset so it tracks the pin while reset is held.
  always_ff @(posedge clk) begin
    sync1_q <= tx_handoff;
    sync2_q <= sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      seen_q  <= sync2_q;
      armed_q <= 1'b1;
    end
  end

  assign req = armed_q && (sync2_q != seen_q);

  always_comb begin
    byte_val = wcrc_q;
    unique case (kind_q)
      K_INFO: begin
        unique case (byte_q[1:0])
          2'd0:    byte_val = 8'h05;
          2'd1:    byte_val = 8'h00;
          default: byte_val = pak_status;
        endcase
      end
      K_STAT: begin
        unique case (byte_q[1:0])
          2'd0:    byte_val = buttons[31:24];
          2'd1:    byte_val = btn_q[23:16];
          2'd2:    byte_val = btn_q[15:8];
          default: byte_val = btn_q[7:0];
        endcase
      end
      K_READ:  byte_val = byte_q[5] ? crca_q : mem_rdata;
      default: byte_val = wcrc_q;
    endcase
  end

  always_comb begin
    dur_m1 = 2'd0;
    unique case (1'b1)
      state_q == S_TURN: dur_m1 = TURN_M1;
      state_q == S_BITL: dur_m1 = sh_q[7] ? 2'd0 : 2'd2;
      state_q == S_BITH: dur_m1 = sh_q[7] ? 2'd2 : 2'd0;
      state_q == S_STPL: dur_m1 = 2'd1;
      default:           dur_m1 = 2'd0;
    endcase
  end

  assign done = (pre_q == PRE_MAX) && (us_q == dur_m1);
  assign last = (byte_q == len_q - 6'd1);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    kind_d  = kind_q;
    sh_d    = sh_q;
    crca_d  = crca_q;
    btn_d   = btn_q;
    addr_d  = addr_q;
    wcrc_d  = wcrc_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      us_d  = us_q + 2'd1;
    end else begin
      pre_d = pre_q + PW'(1);
      us_d  = us_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = address[15:5];
          wcrc_d = crc;
          bit_d  = 3'd0;
          byte_d = 6'd0;
          crca_d = 8'h00;
          unique case (cmd)
            8'h00, 8'hFF: begin
              kind_d = K_INFO; len_d = 6'd3; state_d = S_TURN;
            end
            8'h01: begin
              kind_d = K_STAT; len_d = 6'd4; state_d = S_TURN;
            end
            8'h02: begin
              kind_d = K_READ; len_d = 6'd33; state_d = S_TURN;
            end
            8'h03: begin
              kind_d = K_WRIT; len_d = 6'd1; state_d = S_TURN;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_TURN: if (done) state_d = S_LOAD;
      S_LOAD: begin
        sh_d = byte_val;
        if (kind_q == K_READ && !byte_q[5]) begin
          crca_d = crc8_step(crca_q ^ mem_rdata);
        end
        if (kind_q == K_STAT && byte_q == 6'd0) begin
          btn_d = buttons[23:0];
        end
        state_d = S_BITL;
      end
      S_BITL: if (done) state_d = S_BITH;
      S_BITH: begin
        if (done) begin
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = S_BITL;
          end else if (last) begin
            state_d = S_STPL;
          end else begin
            bit_d   = 3'd0;
            byte_d  = byte_q + 6'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_STPL: if (done) state_d = S_STPH;
      S_STPH: if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A high phase followed by LOAD starts one clk in to keep the 4 us grid.
    if (state_d != state_q) begin
      us_d  = 2'd0;
      pre_d = (state_d == S_BITH && bit_q == 3'd7 && !last) ?
              PW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      us_q      <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 6'd0;
      len_q     <= 6'd0;
      kind_q    <= K_INFO;
      sh_q      <= 8'h00;
      crca_q    <= 8'h00;
      btn_q     <= 24'h0;
      addr_q    <= 11'h0;
      wcrc_q    <= 8'h00;
      data_tx_q <= 1'b1;
      cur_op_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      us_q      <= us_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      len_q     <= len_d;
      kind_q    <= kind_d;
      sh_q      <= sh_d;
      crca_q    <= crca_d;
      btn_q     <= btn_d;
      addr_q    <= addr_d;
      wcrc_q    <= wcrc_d;
      data_tx_q <= !(state_d == S_BITL || state_d == S_STPL);
      cur_op_q  <= (state_d != S_IDLE);
    end
  end

  assign mem_addr      = {addr_q, byte_q[4:0]};
  assign data_tx       = data_tx_q;
  assign cur_operation = cur_op_q;

endmodule

// File: doc/fake_n64_controller_tx.md
# fake_n64_controller_tx

Response transmitter for the fake N64 controller. It sits directly downstream of the controller receive path and consumes its `cmd`/`address`/`crc` outputs and its `tx_handoff` toggle. For each recognised command it serialises the reply onto the single-wire N64 line using the standard 4 µs bit cell and controller stop bit. It holds `cur_operation` high while it owns the line, so the receive path ignores the block's own transmission.

## Interface
- `CLKS_PER_US`, 50, `clk` cycles per microsecond; must be ≥ 2.
- `TURNAROUND_US`, 2, idle µs between detecting the handoff and the first falling edge.
- `clk`  in  1  system clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_handoff`  in  1  toggle from the receive path; every change requests one response. Asynchronous to `clk`.
- `cmd`  in  8  received command; stable while the toggle is pending.
- `address`  in  16  received pak address; bits [15:5] form the 32-byte block base.
- `crc`  in  8  data CRC of the received write payload.
- `buttons`  in  32  controller state; byte 0 is [31:24].
- `pak_status`  in  8  third byte of the INFO reply.
- `mem_addr`  out  16  pak read address, `{address[15:5], byte_idx[4:0]}`.
- `mem_rdata`  in  8  pak read data, valid 1 clk after `mem_addr` changes.
- `data_tx`  out  1  1 = release the line (pulled up), 0 = drive low.
- `cur_operation`  out  1  1 while a response is in progress.

## Operation
- `tx_handoff` passes through a 2-flop synchroniser, then a last-seen register. A mismatch between the synchronised value and the last-seen register is a request.
- On the first clock after reset deassert, the last-seen register loads the synchronised value without raising a request.
- Requests are accepted only in IDLE. A request arriving in any other state is dropped: last-seen is updated, no response is sent.
- On accept, the block latches `cmd`, `address`, and `crc`, and decodes the reply length `len`:
  - 0x00 / 0xFF INFO/RESET: `len`=3, bytes 0x05, 0x00, `pak_status`.
  - 0x01 STATUS: `len`=4, bytes `buttons[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`. All 32 bits are snapshotted when byte 0 loads.
  - 0x02 READ: `len`=33, bytes `mem_rdata` for `byte_idx` 0..31, then the computed data CRC.
  - 0x03 WRITE: `len`=1, the latched `crc`.
  - Any other value: no reply. The block returns to IDLE, and `cur_operation` never rises.
- Data CRC:
  - CRC-8, polynomial 0x85, init 0x00, MSB-first.
  - Computed over the 256 read bits, then augmented with 8 zero bits.
  - Computed on the fly as each byte loads. Must not add bit time.
- Bits are sent MSB-first, byte 0 first.
  - '0' cell: 3 µs low, 1 µs high.
  - '1' cell: 1 µs low, 3 µs high.
  - Stop bit after the last byte: 2 µs low, then release.
- States:
  - IDLE → TURNAROUND on accept, for a known command.
  - TURNAROUND → LOAD.
  - LOAD: 1 clk wait for `mem_rdata` → BIT_LOW.
  - BIT_LOW → BIT_HIGH.
  - BIT_HIGH → BIT_LOW for the next bit, LOAD for the next byte, or STOP_LOW after bit 7 of byte `len`-1.
  - STOP_LOW → STOP_HIGH.
  - STOP_HIGH lasts 1 µs → IDLE.
- Counters:
  - µs prescaler, reloaded at every state change.
  - µs counter, 2 bits.
  - bit index, 3 bits.
  - byte index, 6 bits. `mem_addr` low bits = `byte_idx[4:0]`.

## Timing
- Reset values: `data_tx`=1, `cur_operation`=0, `mem_addr`=0x0000, state IDLE, all counters 0.
- Reset assertion is immediate and asynchronous: it releases the line mid-bit with no stop bit.
- Request detect: `cur_operation` rises 2–3 clk after the `tx_handoff` edge. The spread comes from synchroniser phase.
- First `data_tx` fall: exactly `TURNAROUND_US*CLKS_PER_US` + 1 clk after `cur_operation` rises. The +1 is the LOAD cycle.
- Bit cells are exactly `4*CLKS_PER_US` clk, except the first bit of each byte. That bit is preceded by the 1-clk LOAD, which is absorbed into the previous cell's high phase, so every byte starts on a 4 µs boundary +1 clk.
- `mem_addr` updates in the cycle LOAD is entered. `mem_rdata` is sampled at the end of LOAD.
- `cur_operation` falls `CLKS_PER_US` clk after the stop-bit release. A new request is accepted on the following clk.
- `data_tx` is registered; no glitches.

## Test plan
- INFO: `pak_status`=0x01, toggle `tx_handoff`, `cmd`=0x00 → line decodes 0x05 0x00 0x01, then a 2 µs-low stop bit. First fall comes 2 µs + 1 clk after `cur_operation` rises.
- STATUS: `cmd`=0x01, `buttons`=0x12345678 → bytes 0x12 0x34 0x56 0x78. Every '0' is 150 clk low / 50 high and every '1' is 50 low / 150 high (`CLKS_PER_US`=50).
- READ: `address`=0x8035, memory returns zeros → `mem_addr` steps 0x8020..0x803F; 32 bytes 0x00, then CRC 0x00. A second run against a reference model with random data must match the model's CRC.
- WRITE: `cmd`=0x03, `crc`=0xA5 → exactly one byte 0xA5, then the stop bit. Total line activity is 8×4 µs + 2 µs.
- Unknown `cmd`=0x7E toggle → `data_tx` stays 1 and `cur_operation` stays 0. A second toggle sent during a STATUS reply is ignored: no second response.
- Drive `reset_n` low during BIT_LOW of byte 1 → `data_tx`=1 and `cur_operation`=0 the same instant. With `tx_handoff` held at 1 across reset, no response occurs after release.
